atctlc2axi500_skid_buffer: RTL and testbench
============================================

# atctlc2axi500_skid_buffer

Two-entry fully registered handshake buffer that breaks both the forward path (valid/data) and the backward path (ready) between a producer and a consumer. It is the registered-output counterpart of the bypass elastic buffer used on the same TLC-to-AXI crossing. The bypass buffer gives zero latency with combinational valid/data. This block gives one-cycle latency with every output driven straight from a flop, so it can close timing at the AXI500-facing boundary.

## Interface
- DW, 32, payload width in bits.
- RAR_SUPPORT, 0, when 1 the data registers are reset to zero; when 0 the data registers have no reset.
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- i_valid  input  1  producer has data on din.
- i_ready  output  1  buffer can accept; driven directly from a flop.
- din  input  DW  producer payload.
- o_valid  output  1  dout holds valid data; driven directly from a flop.
- o_ready  input  1  consumer accepts dout.
- dout  output  DW  payload; driven directly from the output data register.
- o_count  output  2  entries held, 0..2.

## Operation
- Storage:
  - out_r: the output register that drives dout.
  - skid_r: holds the word accepted in the cycle the consumer stalled.
- Transfers:
  - Input handshake: i_valid & i_ready.
  - Output handshake: o_valid & o_ready.
- States, with outputs held by flops:
  - EMPTY: o_valid=0, i_ready=1, o_count=0.
  - BUSY: o_valid=1, i_ready=1, o_count=1.
  - FULL: o_valid=1, i_ready=0, o_count=2.
- Transitions, evaluated on each rising edge:
  - EMPTY, input handshake: out_r<=din, go to BUSY. With no input, stay in EMPTY.
  - BUSY, input and output handshake together: out_r<=din, stay in BUSY. This is full throughput.
  - BUSY, input handshake only: skid_r<=din, go to FULL. out_r is unchanged.
  - BUSY, output handshake only: go to EMPTY.
  - BUSY, no handshake: hold.
  - FULL, o_ready=1: out_r<=skid_r, go to BUSY.
  - FULL, o_ready=0: hold.
  - In FULL, i_valid is ignored because i_ready=0.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- dout is stable, and o_valid stays high, from the cycle o_valid rises until the output handshake completes.
- The producer may drop i_valid without a handshake. The buffer samples din only on an input handshake.
- Data register write enables are qualified by the handshake only, so din/dout content outside a handshake has no effect.

## Timing
- Latency: a word accepted at edge N appears on dout with o_valid=1 after edge N. The consumer can take it at edge N+1.
- Sustained throughput is 1 word/cycle. i_ready never drops while the consumer is taking every word.
- After a consumer stall, i_ready falls one cycle after the stalled input handshake. At most one extra word (the skid) is absorbed.
- After FULL, the first o_ready edge restores i_ready=1 in the next cycle.
- No combinational path exists from any input to any output.
- Reset is synchronous. At any edge with reset=1:
  - state goes to EMPTY, so o_valid=0, i_ready=1, o_count=0 from that edge.
  - In-flight contents are discarded, including a reset asserted while in FULL.
  - Handshakes in that cycle are ignored.
  - out_r and skid_r go to 0 only when RAR_SUPPORT=1; otherwise they hold.
- Before the first reset edge, output values are undefined. The bench must apply reset for at least 1 cycle.

## Test plan
- Reset with i_valid=1, din=0xA5A5A5A5 -> during and after reset: o_valid=0, i_ready=1, o_count=0. With RAR_SUPPORT=1, dout=0.
- Single word, din=0x11 at edge 0, o_ready=1 -> at edge 1 o_valid=1, dout=0x11. After edge 1: o_valid=0, o_count=0.
- Streaming: 16 words 0..15 back-to-back with o_ready=1 -> i_ready held at 1 throughout, dout=0..15 on consecutive cycles, one cycle after the input.
- Stall with o_ready=0 and words 0x1, 0x2, 0x3 offered -> 0x1 and 0x2 accepted; i_ready=0 and o_count=2 from the cycle after 0x2. Then release o_ready -> dout=0x1, then 0x2, then 0x3, in order.
- Random i_valid and o_ready over 10k cycles against a reference FIFO model -> output sequence identical to input, o_count within 0..2, dout stable while o_valid & ~o_ready.
- Reset asserted while in FULL, holding 0x7 and 0x8 -> next cycle EMPTY, neither 0x7 nor 0x8 is ever delivered, and the first post-reset word 0x9 arrives intact.

Source files
------------

// File: rtl/atctlc2axi500_skid_buffer.sv
// Two-entry registered skid buffer for the TLC-to-AXI500 crossing.
// Every output comes straight from a flop, so neither valid/data nor ready is combinational.
module atctlc2axi500_skid_buffer #(
    parameter int DW          = 32,
    parameter int RAR_SUPPORT = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] din,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] dout,
    output logic [1:0]    o_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            in_hs;
    logic            out_hs;
    logic            load_out_din;
    logic            load_out_skid;
    logic            load_skid;
    logic            valid_d;
    logic            ready_d;
    logic [1:0]      count_d;
    logic [DW-1:0]   out_r;
    logic [DW-1:0]   skid_r;

    assign in_hs  = i_valid & i_ready;
    assign out_hs = o_valid & o_ready;
    assign dout   = out_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the data-register load strobes; every strobe requires a handshake.
    always_comb begin
        state_d       = state_q;
        load_out_din  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    load_out_din = 1'b1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (in_hs && out_hs) begin
                    load_out_din = 1'b1;
                end else if (in_hs) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_hs) begin
                    load_out_skid = 1'b1;
                    state_d       = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Flag values are decoded from the next state so they can be registered alongside it.
    always_comb begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        count_d = 2'd0;
        case (state_d)
            BUSY: begin
                valid_d = 1'b1;
                ready_d = 1'b1;
                count_d = 2'd1;
            end
            FULL: begin
                valid_d = 1'b1;
                ready_d = 1'b0;
                count_d = 2'd2;
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                count_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            i_ready <= 1'b1;
            o_count <= 2'd0;
        end else begin
            o_valid <= valid_d;
            i_ready <= ready_d;
            o_count <= count_d;
        end
    end

    // Without RAR_SUPPORT the payload flops keep their contents through reset.
    generate
        if (RAR_SUPPORT != 0) begin : g_rar
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_r  <= '0;
                    skid_r <= '0;
                end else begin
                    if (load_out_din) begin
                        out_r <= din;
                    end else if (load_out_skid) begin
                        out_r <= skid_r;
                    end
                    if (load_skid) begin
                        skid_r <= din;
                    end
                end
            end
        end else begin : g_norar
            always_ff @(posedge clk) begin
                if (!reset) begin
                    if (load_out_din) begin
                        out_r <= din;
                    end else if (load_out_skid) begin
                        out_r <= skid_r;
                    end
                    if (load_skid) begin
                        skid_r <= din;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_atctlc2axi500_skid_buffer.sv
// Scoreboard bench for the skid buffer: a depth-2 FIFO model predicts contents and flags,
// and a negedge monitor checks the DUT against it, popping on every output handshake.
module tb_atctlc2axi500_skid_buffer;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] din;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] dout;
    logic [1:0]  o_count;

    logic [31:0] exp_q[$];
    int          model_cnt;
    bit          armed;
    int          checks;
    int          failures;

    atctlc2axi500_skid_buffer #(
        .DW         (32),
        .RAR_SUPPORT(1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .din    (din),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .dout   (dout),
        .o_count(o_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a plain two-deep FIFO; acceptance needs room, delivery needs a word and o_ready.
    initial begin
        bit in_acc;
        bit out_acc;
        model_cnt = 0;
        armed     = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                model_cnt = 0;
                exp_q.delete();
                armed = 1'b1;
            end else if (armed) begin
                in_acc  = i_valid && (model_cnt < 2);
                out_acc = o_ready && (model_cnt > 0);
                if (in_acc) exp_q.push_back(din);
                model_cnt = model_cnt + int'(in_acc) - int'(out_acc);
            end
        end
    end

    // Monitor: flags and dout against the model; the head word is consumed on each output handshake.
    initial begin
        logic [31:0] popped;
        forever begin
            @(negedge clk);
            if (armed) begin
                checkOutput("o_valid", 32'(o_valid), 32'(model_cnt > 0));
                checkOutput("i_ready", 32'(i_ready), 32'(model_cnt < 2));
                checkOutput("o_count", 32'(o_count), 32'(model_cnt));
                if (model_cnt > 0) begin
                    if (exp_q.size() == 0) checkOutput("queue_nonempty", 32'(exp_q.size()), 32'(model_cnt));
                    else checkOutput("dout", dout, exp_q[0]);
                end
                if (!reset && o_valid && o_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("spurious_output", dout, 32'hFFFF_FFFF);
                    end else begin
                        popped = exp_q.pop_front();
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
        @(posedge clk);
        #1;
        i_valid = v;
        din     = d;
        o_ready = r;
    endtask

    // Holds the word on din until the model says it will be taken at the next edge.
    task automatic offerWord(input logic [31:0] d, input logic r);
        bit taken;
        taken = 1'b0;
        for (int k = 0; k < 20 && !taken; k++) begin
            applyStimulus(1'b1, d, r);
            if (model_cnt < 2) taken = 1'b1;
        end
        if (!taken) checkOutput("offer_timeout", 32'(taken), 32'd1);
    endtask

    task automatic applyReset(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            reset   = 1'b1;
            i_valid = 1'b1;
            din     = 32'hA5A5_A5A5;
            o_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        checkOutput("reset_dout_zero", dout, 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        i_valid  = 1'b1;
        din      = 32'hA5A5_A5A5;
        o_ready  = 1'b1;
        applyReset(2);

        // Single word
        applyStimulus(1'b1, 32'h11, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Back-to-back stream
        for (int w = 0; w < 16; w++) applyStimulus(1'b1, 32'(w), 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Consumer stall then release
        applyStimulus(1'b1, 32'h1, 1'b0);
        applyStimulus(1'b1, 32'h2, 1'b0);
        applyStimulus(1'b1, 32'h3, 1'b0);
        applyStimulus(1'b1, 32'h3, 1'b0);
        offerWord(32'h3, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'h0, 1'b1);

        // Reset while full, then a fresh word
        applyStimulus(1'b1, 32'h7, 1'b0);
        applyStimulus(1'b1, 32'h8, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyReset(1);
        offerWord(32'h9, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'h0, 1'b1);

        // Random traffic with per-segment bias
        for (int seg = 0; seg < 10; seg++) begin
            int pv;
            int pr;
            pv = $urandom_range(20, 95);
            pr = $urandom_range(20, 95);
            for (int c = 0; c < 1000; c++) begin
                applyStimulus(1'($urandom_range(0, 99) < pv), $urandom, 1'($urandom_range(0, 99) < pr));
            end
        end
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
